// File: rtl/sine_ctrl_pkg.sv
// Shared types and default widths for the sine burst sequencer.
// The packed config struct is sized by the DEF_* widths below.
package sine_ctrl_pkg;

    localparam int DEF_PHASE_W = 8;
    localparam int DEF_FTW_W   = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        FINISH
    } state_t;

    typedef struct packed {
        logic [DEF_FTW_W-1:0]   ftw;
        logic [DEF_PHASE_W-1:0] offset;
        logic [DEF_CNT_W-1:0]   cycles;
    } sine_cfg_t;

endpackage

// File: rtl/sine_burst_ctrl_if.sv
// Burst configuration valid/ready channel.
// The host is the master and the sequencer is the slave.
interface sine_burst_ctrl_if
    import sine_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int FTW_W   = DEF_FTW_W,
    parameter int CNT_W   = DEF_CNT_W
);
    logic               valid;
    logic               ready;
    logic [FTW_W-1:0]   ftw;
    logic [PHASE_W-1:0] offset;
    logic [CNT_W-1:0]   cycles;

    modport master (
        output valid,
        output ftw,
        output offset,
        output cycles,
        input  ready
    );

    modport slave (
        input  valid,
        input  ftw,
        input  offset,
        input  cycles,
        output ready
    );
endinterface

// File: rtl/sine_wrap_det.sv
// Phase wrap detector: flags a cycle whose phase is below the
// previous cycle's phase. clear forces the history back to zero.
module sine_wrap_det #(
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [PHASE_W-1:0] phase,
    output logic               wrap
);
    logic [PHASE_W-1:0] phase_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_prev <= '0;
        end else if (clear) begin
            phase_prev <= '0;
        end else begin
            phase_prev <= phase;
        end
    end

    assign wrap = (phase < phase_prev);
endmodule

// File: rtl/sine_burst_ctrl.sv
// Burst sequencer for the sine phase accumulator.
// Define SINE_CTRL_SHADOW_EN for a one-entry seamless reconfig shadow.
module sine_burst_ctrl
    import sine_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int FTW_W   = DEF_FTW_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    sine_burst_ctrl_if.slave   cfg,
    input  logic               stop_req,
    input  logic               abort,
    input  logic [PHASE_W-1:0] acc_phase,
    output logic               acc_enable,
    output logic               acc_clear,
    output logic [FTW_W-1:0]   acc_ftw,
    output logic [PHASE_W-1:0] acc_offset,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycles_done
);
    state_t     state;
    sine_cfg_t  act;
    sine_cfg_t  cfg_in;
    logic       stop_pending;
    logic       wrap;
    logic       accept;
    logic       hit;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SINE_CTRL_SHADOW_EN
    sine_cfg_t  shadow;
    logic       shadow_full;

    assign cfg.ready = (state == IDLE)
                     | ((state == RUN) & ~shadow_full);
`else
    assign cfg.ready = (state == IDLE);
`endif

    assign accept = cfg.valid & cfg.ready;
    assign cfg_in = '{ftw: cfg.ftw, offset: cfg.offset, cycles: cfg.cycles};

    assign acc_ftw    = act.ftw;
    assign acc_offset = act.offset;

    // Saturating wrap count; only reachable in continuous mode.
    assign cnt_inc = (&cycles_done) ? cycles_done : cycles_done + 1'b1;

    assign hit = wrap
               & (((act.cycles != '0) & (cnt_inc == act.cycles))
                  | stop_pending);

    sine_wrap_det #(
        .PHASE_W (PHASE_W)
    ) u_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ARM),
        .phase   (acc_phase),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            act          <= '0;
            stop_pending <= 1'b0;
            acc_enable   <= 1'b0;
            acc_clear    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cycles_done  <= '0;
`ifdef SINE_CTRL_SHADOW_EN
            shadow       <= '0;
            shadow_full  <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            acc_clear <= 1'b0;
            unique case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (accept) begin
                        act         <= cfg_in;
                        cycles_done <= '0;
                        acc_clear   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= RUN;
                        acc_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        acc_enable <= 1'b0;
`ifdef SINE_CTRL_SHADOW_EN
                        shadow_full <= 1'b0;
`endif
                    end else begin
                        if (stop_req) begin
                            stop_pending <= 1'b1;
                        end
                        if (wrap) begin
                            cycles_done <= cnt_inc;
                        end
                        if (hit) begin
                            state      <= FINISH;
                            acc_enable <= 1'b0;
                            done       <= 1'b1;
                        end
`ifdef SINE_CTRL_SHADOW_EN
                        // Completion or stop takes priority over a switch.
                        if (hit) begin
                            shadow_full <= 1'b0;
                        end else if (wrap && shadow_full) begin
                            act         <= shadow;
                            cycles_done <= '0;
                            done        <= 1'b1;
                            shadow_full <= 1'b0;
                        end else if (accept) begin
                            shadow      <= cfg_in;
                            shadow_full <= 1'b1;
                        end
`endif
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sine_burst_ctrl.sv
// Self-checking bench for sine_burst_ctrl with an accumulator model
// and a behavioural reference checked every cycle out of reset.
module tb_sine_burst_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stop_req = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] acc_phase;
    logic       acc_enable, acc_clear, busy, done;
    logic [7:0] acc_ftw, acc_offset;
    logic [15:0] cycles_done;

`ifdef SINE_CTRL_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    sine_burst_ctrl_if #(.PHASE_W(8), .FTW_W(8), .CNT_W(16)) cfg_if ();

    sine_burst_ctrl dut (
        .clk         (clk),
        .reset_n     (rst_n),
        .cfg         (cfg_if),
        .stop_req    (stop_req),
        .abort       (abort),
        .acc_phase   (acc_phase),
        .acc_enable  (acc_enable),
        .acc_clear   (acc_clear),
        .acc_ftw     (acc_ftw),
        .acc_offset  (acc_offset),
        .busy        (busy),
        .done        (done),
        .cycles_done (cycles_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_en = 0, n_clr = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Phase accumulator driven by the DUT, as the real datapath would be.
    logic [7:0] acc_ph;
    assign acc_phase = acc_ph + acc_offset;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_ph <= 8'd0;
        else if (acc_clear) acc_ph <= 8'd0;
        else if (acc_enable) acc_ph <= acc_ph + acc_ftw;
    end

    // Reference: mode 0 idle, 1 arm, 2 run, 3 finish.
    int ms = 0, m_ftw = 0, m_off = 0, m_lim = 0, m_cnt = 0, m_prev = 0;
    bit m_en = 0, m_clr = 0, m_busy = 0, m_done = 0, m_stop = 0;
    bit m_sf = 0;
    int s_ftw = 0, s_off = 0, s_lim = 0;

    function automatic bit m_ready();
        return (ms == 0) || (SH && ms == 2 && !m_sf);
    endfunction

    task automatic model_step();
        bit acc, w, fin;
        int nc;
        acc = (cfg_if.valid === 1'b1) && m_ready();
        w   = (ms == 2) && (int'(acc_phase) < m_prev);
        nc  = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        fin = w && ((m_lim != 0 && nc == m_lim) || m_stop);
        m_prev = (ms == 1) ? 0 : int'(acc_phase);
        m_done = 0;
        m_clr  = 0;
        case (ms)
            0: begin
                m_stop = 0;
                if (acc) begin
                    m_ftw = cfg_if.ftw; m_off = cfg_if.offset; m_lim = cfg_if.cycles;
                    m_cnt = 0; m_clr = 1; m_busy = 1; ms = 1;
                end
            end
            1: if (abort) begin ms = 0; m_busy = 0; end
               else begin ms = 2; m_en = 1; end
            2: if (abort) begin
                   ms = 0; m_busy = 0; m_en = 0; m_sf = 0;
               end else begin
                   if (w) m_cnt = nc;
                   if (fin) begin ms = 3; m_en = 0; m_done = 1; m_sf = 0; end
                   else if (SH && w && m_sf) begin
                       m_ftw = s_ftw; m_off = s_off; m_lim = s_lim;
                       m_cnt = 0; m_done = 1; m_sf = 0;
                   end else if (SH && acc) begin
                       s_ftw = cfg_if.ftw; s_off = cfg_if.offset; s_lim = cfg_if.cycles;
                       m_sf = 1;
                   end
                   if (stop_req) m_stop = 1;
               end
            default: begin ms = 0; m_busy = 0; end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ms = 0; m_ftw = 0; m_off = 0; m_lim = 0; m_cnt = 0; m_prev = 0;
            m_en = 0; m_clr = 0; m_busy = 0; m_done = 0; m_stop = 0; m_sf = 0;
        end else begin
            model_step();
        end
    end

    // Every-cycle compare against the reference.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("acc_enable", acc_enable, m_en);
            chk("acc_clear", acc_clear, m_clr);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("acc_ftw", acc_ftw, m_ftw);
            chk("acc_offset", acc_offset, m_off);
            chk("cycles_done", cycles_done, m_cnt);
            chk("cfg_ready", cfg_if.ready, m_ready());
            if (done === 1'b1) n_done++;
            if (acc_enable === 1'b1) n_en++;
            if (acc_clear === 1'b1) n_clr++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_done = 0; n_en = 0; n_clr = 0;
    endtask

    task automatic send(input int f, input int o, input int c);
        cfg_if.valid = 1'b1;
        cfg_if.ftw = 8'(f); cfg_if.offset = 8'(o); cfg_if.cycles = 16'(c);
        chk("send_ready", cfg_if.ready, 1);
        sync();
        cfg_if.valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
    endtask

    task automatic wait_cnt(input int n, input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (cycles_done === 16'(n)) seen = 1;
        end
        chk("cnt_reached", 32'(seen), 1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        sync();
        abort = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.valid = 1'b0; cfg_if.ftw = '0; cfg_if.offset = '0; cfg_if.cycles = '0;
        #2;
        chk("rst_ready", cfg_if.ready, 1);
        chk("rst_en", acc_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cycles_done, 0);
        repeat (3) sync();
        rst_n = 1'b1;

        // Three-period burst: latency, wrap count, single done.
        sync(); clr_cnt();
        send(32, 0, 3);
        @(negedge clk);
        chk("t1_arm_clr", acc_clear, 1);
        chk("t1_arm_en", acc_enable, 0);
        @(negedge clk);
        chk("t1_run_clr", acc_clear, 0);
        chk("t1_run_en", acc_enable, 1);
        wait_done(100);
        chk("t1_cnt", cycles_done, 3);
        @(negedge clk);
        chk("t1_ready", cfg_if.ready, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ndone", n_done, 1);
        chk("t1_nen", n_en, 25);

        // Continuous mode, graceful stop mid-period.
        sync(); clr_cnt();
        send(64, 0, 0);
        repeat (6) sync();
        stop_req = 1'b1;
        sync();
        stop_req = 1'b0;
        wait_done(50);
        chk("t2_cnt", cycles_done, 2);
        chk("t2_nen", n_en, 9);
        chk("t2_en", acc_enable, 0);

        // Abort after two wraps of a five-period burst.
        sync(); clr_cnt();
        send(16, 0, 5);
        wait_cnt(2, 100);
        pulse_abort();
        @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_en", acc_enable, 0);
        repeat (3) @(negedge clk);
        chk("t3_cnt", cycles_done, 2);
        chk("t3_ndone", n_done, 0);

        // Zero tuning word never wraps.
        sync(); clr_cnt();
        send(0, 0, 1);
        repeat (40) sync();
        chk("t4_busy", busy, 1);
        chk("t4_cnt", cycles_done, 0);
`ifndef SINE_CTRL_SHADOW_EN
        cfg_if.valid = 1'b1;
        chk("t4_run_ready", cfg_if.ready, 0);
        sync();
        cfg_if.valid = 1'b0;
`endif
        pulse_abort();
        chk("t4_abort_busy", busy, 0);
        chk("t4_ndone", n_done, 0);

        // Asynchronous reset mid-burst, then a fresh burst with offset.
        sync();
        send(32, 0, 0);
        repeat (10) sync();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_en", acc_enable, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ftw", acc_ftw, 0);
        chk("t5_cnt", cycles_done, 0);
        chk("t5_ready", cfg_if.ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        sync(); clr_cnt();
        send(32, 16, 2);
        repeat (3) @(negedge clk);
        chk("t5_off", acc_offset, 16);
        wait_done(100);
        chk("t5_cnt2", cycles_done, 2);
        chk("t5_ndone", n_done, 1);

`ifdef SINE_CTRL_SHADOW_EN
        // Seamless switch from ftw 32 to ftw 64 at the next wrap.
        sync();
        send(32, 0, 0);
        sync(); clr_cnt();
        repeat (2) sync();
        send(64, 0, 0);
        cfg_if.valid = 1'b1;
        #1;
        chk("t6_full_ready", cfg_if.ready, 0);
        cfg_if.valid = 1'b0;
        wait_done(50);
        chk("t6_ftw", acc_ftw, 64);
        chk("t6_cnt0", cycles_done, 0);
        chk("t6_busy", busy, 1);
        repeat (6) @(negedge clk);
        chk("t6_cnt1", cycles_done, 1);
        chk("t6_nclr", n_clr, 0);
        chk("t6_ndone", n_done, 1);
        sync();
        pulse_abort();
        chk("t6_abort_busy", busy, 0);
`endif

        repeat (3) sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
